// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, oversampling factor and transmitter state encodings.
package uart_pkg;

  localparam int SIZEDATA_DEF = 8;
  localparam int SB_TICK_DEF  = 16;
  localparam int OVERSAMPLE   = 16;

  // One-hot encodings so each state decodes from a single flop
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } tx_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, SIZEDATA data bits LSB first, stop bit of SB_TICK ticks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int SIZEDATA = SIZEDATA_DEF,
  parameter int SB_TICK  = SB_TICK_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_tick,
  input  logic                i_tx_start,
  input  logic [SIZEDATA-1:0] i_tx_data,
  output logic                o_tx,
  output logic                o_tx_busy,
  output logic                o_tx_done
);

  localparam int TICK_W = clog2_min1(max_int(OVERSAMPLE, SB_TICK));
  localparam int BIT_W  = clog2_min1(SIZEDATA);

  localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(SIZEDATA - 1);

  tx_state_t           state;
  logic [TICK_W-1:0]   tick_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [SIZEDATA-1:0] shreg;
  logic [SIZEDATA-1:0] shreg_next;

  assign shreg_next = shreg >> 1;

  // o_tx is updated together with each state change so the line is glitch-free and one cycle behind acceptance
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      o_tx      <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_tx_start) begin
            shreg     <= i_tx_data;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            state     <= ST_START;
            o_tx      <= 1'b0;
            o_tx_busy <= 1'b1;
          end
        end

        ST_START: begin
          if (i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= ST_DATA;
              o_tx     <= shreg[0];
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              shreg    <= shreg_next;
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= ST_STOP;
                o_tx    <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                o_tx    <= shreg_next[0];
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (i_tick) begin
            if (tick_cnt == SB_LAST) begin
              tick_cnt  <= '0;
              state     <= ST_IDLE;
              o_tx_busy <= 1'b0;
              o_tx_done <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          tick_cnt  <= '0;
          bit_cnt   <= '0;
          o_tx      <= 1'b1;
          o_tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a monitor decodes the serial line.
module tb_uart_tx;

  localparam int SIZEDATA    = 8;
  localparam int SB_TICK     = 16;
  localparam int TICK_DIV    = 4;
  localparam int FRAME_TICKS = 160;
  localparam int FRAME_LIMIT = 2000;

  logic       i_clock    = 1'b0;
  logic       i_reset_n  = 1'b0;
  logic       i_tick     = 1'b0;
  logic       i_tx_start = 1'b0;
  logic [7:0] i_tx_data  = 8'h00;
  logic       o_tx;
  logic       o_tx_busy;
  logic       o_tx_done;

  int         n_tests         = 0;
  int         n_fail          = 0;
  int         done_count      = 0;
  int         cycle           = 0;
  int         last_done_cycle = -1;
  int         last_gap        = -1;
  bit         tick_en         = 1'b1;
  logic [7:0] exp_q[$];

  uart_tx #(
    .SIZEDATA(SIZEDATA),
    .SB_TICK (SB_TICK)
  ) dut (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_tick    (i_tick),
    .i_tx_start(i_tx_start),
    .i_tx_data (i_tx_data),
    .o_tx      (o_tx),
    .o_tx_busy (o_tx_busy),
    .o_tx_done (o_tx_done)
  );

  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) cycle <= cycle + 1;

  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge i_clock);
      div    = (div + 1) % TICK_DIV;
      i_tick = tick_en && (div == 0);
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Frame decoder: samples each bit mid-way by counting ticks from the start-bit edge
  initial begin
    bit         in_frame;
    int         cnt;
    logic [7:0] rx;
    logic [7:0] cur_exp;
    in_frame = 1'b0;
    cnt      = 0;
    rx       = 8'h00;
    cur_exp  = 8'h00;
    forever begin
      @(posedge i_clock or negedge i_reset_n);
      if (!i_reset_n) begin
        in_frame = 1'b0;
        continue;
      end
      #1;
      if (!i_reset_n) begin
        in_frame = 1'b0;
        continue;
      end
      if (o_tx_done) begin
        done_count++;
        last_done_cycle = cycle;
      end
      if (in_frame) begin
        if (i_tick) begin
          cnt++;
          if (cnt == 8)
            check_output("start_bit", {31'd0, o_tx}, 32'd0);
          else if (cnt >= 24 && cnt <= 16 * SIZEDATA + 8 && (cnt - 8) % 16 == 0)
            rx[(cnt - 24) / 16] = o_tx;
          else if (cnt == 16 * SIZEDATA + 24)
            check_output("stop_bit", {31'd0, o_tx}, 32'd1);
        end
        if (o_tx_done) begin
          check_output("frame_ticks", cnt, FRAME_TICKS);
          check_output("busy_at_done", {31'd0, o_tx_busy}, 32'd0);
          check_output("frame_data", {24'd0, rx}, {24'd0, cur_exp});
          in_frame = 1'b0;
        end
      end else begin
        if (o_tx_done)
          check_output("spurious_done", 32'd1, 32'd0);
        if (o_tx == 1'b0) begin
          in_frame = 1'b1;
          cnt      = 0;
          rx       = 8'h00;
          last_gap = cycle - last_done_cycle;
          check_output("busy_at_start", {31'd0, o_tx_busy}, 32'd1);
          if (exp_q.size() == 0) begin
            check_output("unexpected_frame", 32'd1, 32'd0);
            cur_exp = 8'h00;
          end else begin
            cur_exp = exp_q.pop_front();
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] data, input logic [7:0] expected);
    @(negedge i_clock);
    i_tx_data  = data;
    i_tx_start = 1'b1;
    exp_q.push_back(expected);
    @(negedge i_clock);
    i_tx_start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < FRAME_LIMIT && done_count < target; i++)
      @(negedge i_clock);
    check_output("done_count", done_count, target);
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge i_clock);
      if (i_tick) k++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clock);
    check_output("reset_tx", {31'd0, o_tx}, 32'd1);
    check_output("reset_busy", {31'd0, o_tx_busy}, 32'd0);
    check_output("reset_done", {31'd0, o_tx_done}, 32'd0);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clock);

    // Test 1: 0xA5 -> line 0,1,0,1,0,0,1,0,1,1
    apply_stimulus(8'hA5, 8'hA5);
    wait_done(1);
    check_output("idle_tx_after_a5", {31'd0, o_tx}, 32'd1);

    // Test 2: all-zero then all-one payloads
    apply_stimulus(8'h00, 8'h00);
    wait_done(2);
    apply_stimulus(8'hFF, 8'hFF);
    wait_done(3);

    // Test 3: start request mid-DATA must be ignored
    apply_stimulus(8'h3C, 8'h3C);
    wait_ticks(40);
    @(negedge i_clock);
    i_tx_data  = 8'h99;
    i_tx_start = 1'b1;
    repeat (8) @(negedge i_clock);
    i_tx_start = 1'b0;
    wait_done(4);
    repeat (30) @(negedge i_clock);
    check_output("no_restart_busy", {31'd0, o_tx_busy}, 32'd0);
    check_output("no_restart_tx", {31'd0, o_tx}, 32'd1);
    check_output("single_done", done_count, 4);

    // Test 4: asynchronous reset at tick 70 aborts the frame
    apply_stimulus(8'h5A, 8'h5A);
    wait_ticks(70);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_output("abort_tx", {31'd0, o_tx}, 32'd1);
    check_output("abort_busy", {31'd0, o_tx_busy}, 32'd0);
    check_output("abort_done", {31'd0, o_tx_done}, 32'd0);
    repeat (20) @(negedge i_clock);
    check_output("abort_no_done", done_count, 4);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clock);
    apply_stimulus(8'h5A, 8'h5A);
    wait_done(5);

    // Test 5: start held high gives back-to-back frames
    @(negedge i_clock);
    i_tx_data  = 8'h11;
    i_tx_start = 1'b1;
    exp_q.push_back(8'h11);
    wait_done(6);
    i_tx_data = 8'h22;
    exp_q.push_back(8'h22);
    @(negedge i_clock);
    i_tx_start = 1'b0;
    wait_done(7);
    check_output("b2b_gap", last_gap, 1);

    // Test 6: ticks gated off mid-bit 2 of 0x6B (bit value 0)
    apply_stimulus(8'h6B, 8'h6B);
    wait_ticks(50);
    @(negedge i_clock);
    tick_en = 1'b0;
    repeat (50) @(negedge i_clock);
    check_output("gated_hold_bit", {31'd0, o_tx}, 32'd0);
    check_output("gated_busy", {31'd0, o_tx_busy}, 32'd1);
    tick_en = 1'b1;
    wait_done(8);

    repeat (10) @(negedge i_clock);
    check_output("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter SIZEDATA, default 8, giving data bits per frame.
REQ-002 The block SHALL have parameter SB_TICK, default 16, giving the stop-bit duration in baud ticks.
REQ-003 The block SHALL have port i_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_tick, input, 1 bit: one-cycle baud tick at 16x the bit rate.
REQ-006 The block SHALL have port i_tx_start, input, 1 bit: transmit request, driven by the interface FSM's result-valid signal.
REQ-007 The block SHALL have port i_tx_data, input, SIZEDATA bits: byte to send, normally the ALU result.
REQ-008 The block SHALL have port o_tx, output, 1 bit: registered serial line, idle high.
REQ-009 The block SHALL have port o_tx_busy, output, 1 bit: high while a frame is in progress.
REQ-010 The block SHALL have port o_tx_done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-011 The FSM SHALL have four states: IDLE, START, DATA, STOP, held in a one-hot state register.
REQ-012 In IDLE, a cycle with i_tx_start=1 SHALL latch i_tx_data into a shift register, clear the tick and bit counters, and move to START; i_tick is irrelevant on that cycle.
REQ-013 o_tx SHALL be low from the first cycle after acceptance, giving a one-cycle start latency.
REQ-014 o_tx_busy SHALL be high from the first cycle after acceptance until the cycle the FSM re-enters IDLE.
REQ-015 The tick counter SHALL advance only on cycles with i_tick=1; cycles without a tick SHALL hold all state.
REQ-016 START SHALL hold o_tx=0 for 16 ticks, then enter DATA with the bit index at 0.
REQ-017 DATA SHALL drive the shift-register LSB on o_tx for 16 ticks per bit, shift right after each bit, and send bits LSB first.
REQ-018 After bit SIZEDATA-1, the FSM SHALL enter STOP, with the bit index wrapping to 0.
REQ-019 STOP SHALL hold o_tx=1 for SB_TICK ticks, then pulse o_tx_done for exactly one cycle and return to IDLE on that same edge.
REQ-020 A full frame SHALL last (1+SIZEDATA)*16+SB_TICK ticks: 160 ticks with the defaults.
REQ-021 i_tx_start SHALL be ignored outside IDLE: no queueing and no restart.
REQ-022 Changes on i_tx_data after acceptance SHALL NOT affect the frame in flight.
REQ-023 If i_tx_start is still high in the cycle after the return to IDLE, a new frame SHALL be accepted; back-to-back frames are legal.
REQ-024 Counter widths SHALL be ceil(log2) of their maximum counts; no arithmetic beyond increment and compare.

Reset
REQ-025 i_reset_n low SHALL immediately, without waiting for a clock edge, set: state=IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, and all counters and the shift register to 0.
REQ-026 A reset during a frame SHALL abort it with no o_tx_done pulse; the line returns high at once.
REQ-027 After reset deassertion, the first accepted request SHALL produce a complete, correct frame.

Structure
REQ-028 SIZEDATA, SB_TICK default, oversampling factor 16 and state encodings SHALL live in the shared uart package used by the receiver and interface blocks.
REQ-029 The block SHALL contain no sub-module; the baud tick comes from the sibling block baud_gen, instantiated at top level and shared with the receiver.

Verification
REQ-030 Test 1: i_tx_data=0xA5, 1-cycle i_tx_start -> o_tx holds 0,1,0,1,0,0,1,0,1,1 for 16 ticks each; one o_tx_done pulse at tick 160; o_tx_busy drops the same cycle.
REQ-031 Test 2: send 0x00, then 0xFF -> 8 low data bits, then 8 high data bits; the stop bit is high in both frames.
REQ-032 Test 3: request 0x3C, then assert i_tx_start with 0x99 mid-DATA -> serial output is 0x3C only and exactly one o_tx_done pulse.
REQ-033 Test 4: i_reset_n low at tick 70 of a 0x5A frame -> o_tx=1 and o_tx_busy=0 asynchronously, no o_tx_done; a following 0x5A frame is correct.
REQ-034 Test 5: hold i_tx_start high with 0x11, then 0x22 -> two contiguous frames with no idle gap beyond one cycle, and two o_tx_done pulses.
REQ-035 Test 6: i_tick gated off for 50 cycles mid-bit -> the bit stretches and no state advances; the frame remains valid when ticks resume.
